imem_arbiter: RTL
=================

# imem_arbiter

Two-port arbiter that shares the single combinational instruction-memory read port between the CPU fetch stage (requester 0) and the pattern-matching peripheral's instruction/table fetch (requester 1). It accepts valid/ready address requests, drives one word address per cycle to the memory, and returns the read word through a registered, one-entry-per-requester response buffer. Ties are resolved round-robin, and back-pressure on either response path stalls only that requester.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: instruction word width.
- `clk  in  1`: single clock, rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `req0_valid  in  1`: CPU fetch request.
- `req0_addr  in  ADDR_W`: CPU byte address.
- `req0_ready  out  1`: request 0 accepted this cycle.
- `rsp0_valid  out  1`: response 0 holds data.
- `rsp0_data  out  DATA_W`: word read for requester 0.
- `rsp0_err  out  1`: misaligned request flag (macro-dependent).
- `rsp0_ready  in  1`: requester 0 consumes response.
- `req1_*`, `rsp1_*`: identical set for the peripheral.
- `mem_en  out  1`: a grant is issued this cycle.
- `mem_addr  out  ADDR_W`: byte address to imem, which ignores bits [1:0].
- `mem_data  in  DATA_W`: combinational read data from imem.

## Operation
- Eligibility: requester i is eligible when `reqi_valid` is high and its response slot is free. A slot is free when `!rspi_valid`, or when `rspi_ready` is high in the same cycle.
- Grant selection:
  - One eligible requester: it wins.
  - Both eligible: the requester not granted last wins.
  - `last_grant` updates on every grant.
- `reqi_ready` = grant to i (combinational). A transfer occurs when `reqi_valid && reqi_ready`.
- Memory drive:
  - `mem_en` = any grant.
  - `mem_addr` = address of the granted requester, or 0 when there is no grant.
- Capture: on a grant to i, `rspi_data` ← `mem_data` and `rspi_valid` ← 1 at the same clock edge.
- Release: `rspi_valid` clears on `rspi_valid && rspi_ready` with no new grant to i. A simultaneous consume and grant keeps it at 1 with new data.
- Holding: while `rspi_valid && !rspi_ready`, data and err stay stable and no grant goes to i. The other requester proceeds unaffected.
- Unused input: `reqi_addr` is ignored when `reqi_valid` is low.

## Timing
- Reset (async, `reset_n` low):
  - `rsp0_valid` = `rsp1_valid` = 0.
  - `rsp*_data` = 0, `rsp*_err` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - Combinational outputs (`req*_ready`, `mem_en`, `mem_addr`) are 0 while in reset.
- Latency: a request accepted at edge N has its response visible after edge N (cycle N+1).
- Throughput: one grant per cycle total. A single requester that always consumes sustains 1 word/cycle. Under contention each requester gets 1 word per 2 cycles.
- Starvation bound: a continuously eligible requester is granted within 2 cycles.
- Reset mid-operation: pending responses are discarded and in-flight grants are lost. Requesters must reissue.
- Response stability: `rsp*` outputs change only at clock edges.

## Configuration
- `IMEM_ARB_ALIGN_CHK_EN` defined:
  - A request with `addr[1:0] != 0` is still granted (consumes a slot), but the memory is not read: `mem_en` = 0 that cycle.
  - The response carries `rsp_err` = 1 and `rsp_data` = 0.
  - Aligned requests give `rsp_err` = 0.
- Undefined:
  - `rsp*_err` is tied to 0.
  - Misaligned addresses are passed through and imem returns the word at `addr[31:2]`.

## Test plan
- Single fetch: `req0` at 0x0000_0010, `mem_data` = 0x0050_0093 → `req0_ready` = 1 the same cycle, `mem_addr` = 0x10; next cycle `rsp0_valid` = 1, `rsp0_data` = 0x0050_0093.
- Contention: both valid every cycle, `rsp_ready` = 1 → grants alternate 0,1,0,1 starting with 0 after reset; each requester receives 4 responses in 8 cycles.
- Back-pressure: `rsp1_ready` = 0 with `rsp1_valid` set, `req1` and `req0` valid → `req1_ready` stays 0, `rsp1_data` is stable, `req0` is granted every cycle; raising `rsp1_ready` lets `req1` be granted that same cycle.
- Streaming: `req0` addresses 0x0,0x4,0x8,0xC back-to-back with `rsp0_ready` = 1 → 4 consecutive responses, no bubbles.
- Async reset mid-stream: assert `reset_n` = 0 between edges with `rsp0_valid` = 1 → `rsp0_valid` drops immediately; after release, the first tie goes to requester 0.
- Alignment (macro defined): `req1_addr` = 0x0000_0006 → `mem_en` = 0, next cycle `rsp1_err` = 1 and `rsp1_data` = 0. Without the macro: `rsp1_err` = 0 and data = word at 0x4.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational instruction-memory read port between
// two valid/ready requesters (0 = CPU fetch, 1 = pattern-matching peripheral).
// Ties go round-robin. Each requester has a one-entry registered response slot,
// so back-pressure on one response path stalls only that requester.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqN_valid/addr/ready        request handshake (ready = grant, combinational)
//   rspN_valid/data/err/ready    registered response slot
//   mem_en, mem_addr, mem_data   shared memory read port (data is combinational)
//
// Optional feature: define IMEM_ARB_ALIGN_CHK_EN to flag misaligned requests.
// They are granted but not read from memory, and respond with err = 1, data = 0.
// Without the macro, err is always 0 and misaligned addresses pass through.
module imem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  input  logic              rsp1_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  logic              elig0, elig1, gnt0, gnt1, misalign;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] rd_data;

  // 0: requester 0 was granted last; 1: requester 1 (or nothing since reset).
  logic              last_grant_q, last_grant_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic              rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;

  always_comb begin
    // A slot is free if empty or being drained in this same cycle.
    elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);
    // Gate with reset_n so no grant is visible while held in reset.
    gnt0  = reset_n && elig0 && (!elig1 || last_grant_q);
    gnt1  = reset_n && elig1 && (!elig0 || !last_grant_q);

    gnt_addr = '0;
    if (gnt0) begin
      gnt_addr = req0_addr;
    end else if (gnt1) begin
      gnt_addr = req1_addr;
    end

`ifdef IMEM_ARB_ALIGN_CHK_EN
    misalign = (gnt0 || gnt1) && (gnt_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif

    mem_en   = (gnt0 || gnt1) && !misalign;
    mem_addr = gnt_addr;
    rd_data  = misalign ? '0 : mem_data;

    req0_ready = gnt0;
    req1_ready = gnt1;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    rsp1_err_d   = rsp1_err_q;

    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end

    // A new grant wins over a simultaneous consume: slot stays full with new data.
    if (gnt0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = rd_data;
      rsp0_err_d   = misalign;
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (gnt1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = rd_data;
      rsp1_err_d   = misalign;
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_err_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_err_q   <= rsp1_err_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp1_err   = rsp1_err_q;

endmodule
